// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the up/down button counter.
package count_ctrl_pkg;

  localparam int TMR_W = 27;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_UP = 2'd1,
    HOLD_DN = 2'd2,
    LOCK    = 2'd3
  } ctrlState;

endpackage

// File: rtl/count_ctrl_btn_edge.sv
// Registered button level with rising-edge detect; history resets to 1 so a
// button held through reset release never reads as a fresh press.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic levelQ,
  output logic rise
);

  always_ff @(posedge clk) begin
    if (rst) levelQ <= 1'b1;
    else     levelQ <= level;
  end

  assign rise = level & ~levelQ;

endmodule

// File: rtl/count_ctrl.sv
// Up/down button counter with wrap, optional hold-to-repeat
// (enabled by defining COUNT_CTRL_REPEAT_EN).
//
// state   | meaning
// IDLE    | waiting for a fresh press
// HOLD_UP | up pressed and still held
// HOLD_DN | down pressed and still held
// LOCK    | both buttons seen together; wait until both are released
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int MAX_VAL       = 15,
  parameter int DELAY_CYCLES  = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic             Clk100M,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] value,
  output logic             up_p,
  output logic             down_p,
  output logic             wrap_p
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  ctrlState state, stateNext;
  logic     upRise, downRise;
  logic     unusedUpQ, unusedDnQ;
  logic     doInc, doDec;

  btn_edge upEdge (
    .clk(Clk100M), .rst(rst), .level(up), .levelQ(unusedUpQ), .rise(upRise)
  );

  btn_edge dnEdge (
    .clk(Clk100M), .rst(rst), .level(down), .levelQ(unusedDnQ), .rise(downRise)
  );

`ifdef COUNT_CTRL_REPEAT_EN
  localparam logic [TMR_W-1:0] DLY_LD = TMR_W'(DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RPT_LD = TMR_W'(REPEAT_CYCLES - 1);

  logic [TMR_W-1:0] tmr;
  logic             holding, enterHold, stayHold;

  assign holding   = (state == HOLD_UP) || (state == HOLD_DN);
  assign enterHold = (state == IDLE) && ((stateNext == HOLD_UP) || (stateNext == HOLD_DN));
  assign stayHold  = holding && (stateNext == state);

  always_ff @(posedge Clk100M) begin
    if (rst)            tmr <= '0;
    else if (enterHold) tmr <= DLY_LD;
    else if (stayHold)  tmr <= (tmr == '0) ? RPT_LD : tmr - TMR_W'(1);
    else                tmr <= '0;
  end
`else
  logic unusedCfg;
  assign unusedCfg = (DELAY_CYCLES > REPEAT_CYCLES);
`endif

  always_comb begin
    stateNext = state;
    doInc     = 1'b0;
    doDec     = 1'b0;
    case (state)
      IDLE: begin
        if (up && down) stateNext = LOCK;
        else if (upRise) begin
          doInc     = 1'b1;
          stateNext = HOLD_UP;
        end else if (downRise) begin
          doDec     = 1'b1;
          stateNext = HOLD_DN;
        end
      end
      // opposite button wins over a same-cycle release
      HOLD_UP: begin
        if (down)     stateNext = LOCK;
        else if (!up) stateNext = IDLE;
`ifdef COUNT_CTRL_REPEAT_EN
        else if (tmr == '0) doInc = 1'b1;
`endif
      end
      HOLD_DN: begin
        if (up)         stateNext = LOCK;
        else if (!down) stateNext = IDLE;
`ifdef COUNT_CTRL_REPEAT_EN
        else if (tmr == '0) doDec = 1'b1;
`endif
      end
      default: begin
        if (!up && !down) stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (rst) begin
      state  <= IDLE;
      value  <= '0;
      up_p   <= 1'b0;
      down_p <= 1'b0;
      wrap_p <= 1'b0;
    end else begin
      state  <= stateNext;
      up_p   <= doInc;
      down_p <= doDec;
      wrap_p <= (doInc && (value == MAXV)) || (doDec && (value == '0));
      if (doInc)      value <= (value == MAXV) ? '0 : value + WIDTH'(1);
      else if (doDec) value <= (value == '0) ? MAXV : value - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl (WIDTH=4, MAX_VAL=9, DELAY=4, REPEAT=2).
module tb_count_ctrl;

  logic       Clk100M = 1'b0;
  logic       rst, up, down;
  logic [3:0] value;
  logic       up_p, down_p, wrap_p;

  int vecs = 0;
  int errs = 0;
  int expVal = 0;

`ifdef COUNT_CTRL_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  count_ctrl #(.WIDTH(4), .MAX_VAL(9), .DELAY_CYCLES(4), .REPEAT_CYCLES(2)) dut (
    .Clk100M(Clk100M), .rst(rst), .up(up), .down(down),
    .value(value), .up_p(up_p), .down_p(down_p), .wrap_p(wrap_p)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic cyc(input logic u, input logic d);
    up   = u;
    down = d;
    @(posedge Clk100M);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== 7'b0000_000) begin
      errs++;
      $display("FAIL reset: got v=%0d udw=%b%b%b, want v=0 udw=000", value, up_p, down_p, wrap_p);
    end
    rst = 1'b0;
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_single_step;
    cyc(1'b1, 1'b0);
    expVal = 1;
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b100}) begin
      errs++;
      $display("FAIL single_step: got v=%0d udw=%b%b%b, want v=%0d udw=100", value, up_p, down_p, wrap_p, expVal);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0);
      vecs++;
      if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b000}) begin
        errs++;
        $display("FAIL single_after: got v=%0d udw=%b%b%b, want v=%0d udw=000", value, up_p, down_p, wrap_p, expVal);
      end
    end
  endtask

  task automatic test_wrap;
    for (int i = 2; i <= 9; i++) begin
      cyc(1'b1, 1'b0);
      expVal = i;
      vecs++;
      if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b100}) begin
        errs++;
        $display("FAIL climb: got v=%0d udw=%b%b%b, want v=%0d udw=100", value, up_p, down_p, wrap_p, expVal);
      end
      cyc(1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0);
    expVal = 0;
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b101}) begin
      errs++;
      $display("FAIL wrap_up: got v=%0d udw=%b%b%b, want v=0 udw=101", value, up_p, down_p, wrap_p);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    expVal = 9;
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b011}) begin
      errs++;
      $display("FAIL wrap_down: got v=%0d udw=%b%b%b, want v=9 udw=011", value, up_p, down_p, wrap_p);
    end
    cyc(1'b0, 1'b0);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b000}) begin
      errs++;
      $display("FAIL wrap_release: got v=%0d udw=%b%b%b, want v=9 udw=000", value, up_p, down_p, wrap_p);
    end
  endtask

  task automatic test_hold;
    logic stepExp;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    expVal = 0;
    // Repeat build: steps on hold cycles 0,4,6,8,10; otherwise only cycle 0.
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b0);
      stepExp = (k == 0) || (REPEAT && (k == 4 || k == 6 || k == 8 || k == 10));
      if (stepExp) expVal++;
      vecs++;
      if ({value, up_p, down_p, wrap_p} !== {4'(expVal), stepExp, 2'b00}) begin
        errs++;
        $display("FAIL hold k=%0d: got v=%0d udw=%b%b%b, want v=%0d up_p=%b", k, value, up_p, down_p, wrap_p, expVal, stepExp);
      end
    end
    cyc(1'b0, 1'b0);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {(REPEAT ? 4'd5 : 4'd1), 3'b000}) begin
      errs++;
      $display("FAIL hold_final: got v=%0d udw=%b%b%b, want v=%0d udw=000", value, up_p, down_p, wrap_p, REPEAT ? 5 : 1);
    end
  endtask

  task automatic test_lock;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b000}) begin
      errs++;
      $display("FAIL lock_hold: got v=%0d udw=%b%b%b, want v=%0d udw=000", value, up_p, down_p, wrap_p, expVal);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    expVal++;
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b100}) begin
      errs++;
      $display("FAIL lock_exit: got v=%0d udw=%b%b%b, want v=%0d udw=100", value, up_p, down_p, wrap_p, expVal);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_hold_then_down;
    cyc(1'b1, 1'b0);
    expVal++;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b000}) begin
      errs++;
      $display("FAIL hold_to_lock: got v=%0d udw=%b%b%b, want v=%0d udw=000", value, up_p, down_p, wrap_p, expVal);
    end
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b000}) begin
      errs++;
      $display("FAIL lock_no_repeat: got v=%0d udw=%b%b%b, want v=%0d udw=000", value, up_p, down_p, wrap_p, expVal);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    expVal--;
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== {4'(expVal), 3'b010}) begin
      errs++;
      $display("FAIL lock_then_down: got v=%0d udw=%b%b%b, want v=%0d udw=010", value, up_p, down_p, wrap_p, expVal);
    end
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset_hold;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== 7'b0000_000) begin
      errs++;
      $display("FAIL reset_abort: got v=%0d udw=%b%b%b, want v=0 udw=000", value, up_p, down_p, wrap_p);
    end
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0);
      vecs++;
      if ({value, up_p, down_p, wrap_p} !== 7'b0000_000) begin
        errs++;
        $display("FAIL held_after_reset i=%0d: got v=%0d udw=%b%b%b, want v=0 udw=000", i, value, up_p, down_p, wrap_p);
      end
    end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    vecs++;
    if ({value, up_p, down_p, wrap_p} !== 7'b0001_100) begin
      errs++;
      $display("FAIL repress_after_reset: got v=%0d udw=%b%b%b, want v=1 udw=100", value, up_p, down_p, wrap_p);
    end
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst  = 1'b1;
    up   = 1'b0;
    down = 1'b0;
    test_reset;
    test_single_step;
    test_wrap;
    test_hold;
    test_lock;
    test_hold_then_down;
    test_reset_hold;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
